// File: rtl/sram_like_arbiter.sv
// Two-requester SRAM-like arbiter: fixed data priority with fetch anti-starvation, in-order owner FIFO for responses.
// Zero-cycle request and response paths; master lock holds grant until m_addr_ok, no new m_req while OUTSTANDING responses pending.
module sram_like_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s0_req,
    input  logic        s0_wr,
    input  logic [1:0]  s0_size,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    output logic        s0_addr_ok,
    output logic        s0_data_ok,
    output logic [31:0] s0_rdata,
    input  logic        s1_req,
    input  logic        s1_wr,
    input  logic [1:0]  s1_size,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    output logic        s1_addr_ok,
    output logic        s1_data_ok,
    output logic [31:0] s1_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err_spurious
);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] PTR_LAST  = PW'(OUTSTANDING - 1);

    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   lock_q, lock_d, lock_port_q, lock_port_d;

    logic full, gnt_vld, gnt_port, sel_req, accept, pop, head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full     = (count_q == FULL_CNT);
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        // A stalled master request keeps its port so master signals stay stable until accepted.
        if (lock_q) begin
            gnt_vld  = 1'b1;
            gnt_port = lock_port_q;
        end else if (!full && (s0_req || s1_req)) begin
            gnt_vld = 1'b1;
            if (s0_req && !s1_req)      gnt_port = 1'b0;
            else if (s1_req && !s0_req) gnt_port = 1'b1;
            else                        gnt_port = !(starve_q >= STARVE_MX);
        end
    end

    always_comb begin
        sel_req = gnt_port ? s1_req : s0_req;
        m_req   = resetn && gnt_vld && sel_req && !full;
        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        if (gnt_vld) begin
            m_wr    = gnt_port ? s1_wr    : s0_wr;
            m_size  = gnt_port ? s1_size  : s0_size;
            m_addr  = gnt_port ? s1_addr  : s0_addr;
            m_wdata = gnt_port ? s1_wdata : s0_wdata;
        end
    end

    assign accept       = m_req && m_addr_ok;
    assign s0_addr_ok   = accept && !gnt_port;
    assign s1_addr_ok   = accept &&  gnt_port;
    assign head         = owner_q[rd_ptr_q];
    assign pop          = resetn && m_data_ok && (count_q != '0);
    assign s0_data_ok   = pop && !head;
    assign s1_data_ok   = pop &&  head;
    assign err_spurious = resetn && m_data_ok && (count_q == '0);
    assign s0_rdata     = m_rdata;
    assign s1_rdata     = m_rdata;

    always_comb begin
        owner_d     = owner_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        lock_d      = m_req && !m_addr_ok;
        lock_port_d = gnt_port;
        if (accept) begin
            owner_d[wr_ptr_q] = gnt_port;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept && gnt_port && s0_req) begin
            if (starve_q < STARVE_MX) starve_d = starve_q + 1'b1;
        end else if ((accept && !gnt_port) || !s0_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed vector table, hand sequences, then random traffic against a queue-based model.
module tb_sram_like_arbiter;
    localparam int OUT = 2;
    localparam int LIM = 4;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        s0_req = 0, s0_wr = 0, s1_req = 0, s1_wr = 0;
    logic [1:0]  s0_size = 0, s1_size = 0;
    logic [31:0] s0_addr = 0, s0_wdata = 0, s1_addr = 0, s1_wdata = 0;
    logic        s0_addr_ok, s0_data_ok, s1_addr_ok, s1_data_ok;
    logic [31:0] s0_rdata, s1_rdata;
    logic        m_req, m_wr, m_addr_ok = 0, m_data_ok = 0, err_spurious;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata = 0;

    sram_like_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .s0_req(s0_req), .s0_wr(s0_wr), .s0_size(s0_size), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_addr_ok(s0_addr_ok), .s0_data_ok(s0_data_ok), .s0_rdata(s0_rdata),
        .s1_req(s1_req), .s1_wr(s1_wr), .s1_size(s1_size), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_addr_ok(s1_addr_ok), .s1_data_ok(s1_data_ok), .s1_rdata(s1_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // flags = {s0_addr_ok, s1_addr_ok, s0_data_ok, s1_data_ok, err_spurious, m_req}
    typedef struct {
        logic        s0, s1, aok, dok;
        logic [31:0] rdata;
        logic [5:0]  flags;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[18];

    function automatic logic [5:0] flags_now();
        return {s0_addr_ok, s1_addr_ok, s0_data_ok, s1_data_ok, err_spurious, m_req};
    endfunction

    task automatic drive(input logic r0, input logic r1, input logic aok, input logic dok, input logic [31:0] rd);
        s0_req = r0; s1_req = r1; m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: FIFO of owners in issue order, plus arbitration history.
    bit          own[$];
    int          starve;
    bit          held, held_port;
    bit          pend[2];
    logic [31:0] paddr[2], pwd[2];
    logic        pwr[2];
    logic [1:0]  psz[2];
    bit          rst, full, gv, gp, mq, acc, popm, hd;
    bit [1:0]    rq;
    logic [5:0]  ef;
    logic [66:0] em;
    int          exp_g[10];
    int          got_g;

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b100001, 32'hBFC00000},
            '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 32'h0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 32'h24080001, 6'b001000, 32'h0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD0000, 6'b000010, 32'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 32'h0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b100001, 32'hBFC00000},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        6'b010001, 32'h80000100},
            '{1'b1, 1'b0, 1'b1, 1'b1, 32'h11,       6'b001000, 32'h0},
            '{1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       6'b100101, 32'hBFC00000},
            '{1'b0, 1'b0, 1'b0, 1'b1, 32'h33,       6'b001000, 32'h0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000001, 32'h80000100},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000001, 32'h80000100},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000001, 32'h80000100},
            '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        6'b010001, 32'h80000100},
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b100001, 32'hBFC00000},
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000000, 32'h0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 32'h44,       6'b000100, 32'h0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55,       6'b001000, 32'h0}
        };
        exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        s0_addr = 32'hBFC00000; s0_size = 2'd2;
        s1_addr = 32'h80000100; s1_size = 2'd2; s1_wr = 1'b1; s1_wdata = 32'hCAFE0001;

        // Outputs must stay quiet in reset even with every input active.
        #1;
        drive(1, 1, 1, 1, 32'h0);
        repeat (2) begin
            #4 check("reset_quiet", 128'(flags_now()), 128'(6'b0));
            next_cycle();
        end
        resetn = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].s0, tbl[i].s1, tbl[i].aok, tbl[i].dok, tbl[i].rdata);
            #4;
            check($sformatf("vec%0d_flags", i), 128'(flags_now()), 128'(tbl[i].flags));
            check($sformatf("vec%0d_addr", i), 128'(m_addr), 128'(tbl[i].addr));
            check($sformatf("vec%0d_rdata", i), 128'({s0_rdata, s1_rdata}), 128'({tbl[i].rdata, tbl[i].rdata}));
            next_cycle();
        end

        // Contention: both requesting, responses one cycle behind each accept.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, i > 0, 32'h0);
            #4;
            got_g = s1_addr_ok ? 1 : (s0_addr_ok ? 0 : 2);
            check($sformatf("contention%0d", i), 128'(got_g), 128'(exp_g[i]));
            next_cycle();
        end
        drive(0, 0, 0, 1, 32'h0);
        next_cycle();

        // Reset with two transactions outstanding drops them.
        drive(1, 0, 1, 0, 32'h0); next_cycle();
        drive(1, 0, 1, 0, 32'h0); next_cycle();
        resetn = 1'b0;
        drive(1, 0, 1, 1, 32'h0);
        #4 check("reset_full_quiet", 128'(flags_now()), 128'(6'b0));
        next_cycle();
        resetn = 1'b1;
        drive(0, 0, 0, 1, 32'h0);
        #4 check("post_reset_spurious", 128'(flags_now()), 128'(6'b000010));
        next_cycle();
        drive(1, 0, 0, 0, 32'h0);
        #4 check("post_reset_not_full", 128'(flags_now()), 128'(6'b000001));
        next_cycle();

        // Random traffic; start from a clean reset so the model is empty.
        resetn = 1'b0; drive(0, 0, 0, 0, 32'h0); next_cycle(); resetn = 1'b1;
        own.delete(); starve = 0; held = 0; pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1; paddr[p] = $urandom; pwd[p] = $urandom;
                    pwr[p] = 1'($urandom_range(0, 1)); psz[p] = 2'($urandom_range(0, 3));
                end
            end
            resetn = !rst;
            s0_addr = paddr[0]; s0_wdata = pwd[0]; s0_wr = pwr[0]; s0_size = psz[0];
            s1_addr = paddr[1]; s1_wdata = pwd[1]; s1_wr = pwr[1]; s1_size = psz[1];
            drive(pend[0], pend[1], 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom);
            #4;
            if (rst) begin
                check("rand_reset", 128'(flags_now()), 128'(6'b0));
                own.delete(); starve = 0; held = 0; pend[0] = 0; pend[1] = 0;
            end else begin
                rq = {pend[1], pend[0]};
                full = (own.size() == OUT);
                gv = 0; gp = 0;
                if (held) begin gv = 1; gp = held_port; end
                else if (!full && rq != 2'b00) begin
                    gv = 1;
                    gp = (rq == 2'b11) ? (starve < LIM) : rq[1];
                end
                mq   = gv && rq[gp] && !full;
                acc  = mq && m_addr_ok;
                popm = m_data_ok && own.size() > 0;
                hd   = popm ? own[0] : 1'b0;
                ef = {acc && !gp, acc && gp, popm && !hd, popm && hd, m_data_ok && own.size() == 0, mq};
                em = gv ? {pwr[gp], psz[gp], paddr[gp], pwd[gp]} : 67'd0;
                check("rand_flags", 128'(flags_now()), 128'(ef));
                check("rand_master", 128'({m_wr, m_size, m_addr, m_wdata}), 128'(em));
                if (popm) void'(own.pop_front());
                if (acc) begin own.push_back(gp); pend[gp] = 0; end
                held = mq && !m_addr_ok; held_port = gp;
                if (acc && gp && rq[0]) starve = (starve < LIM) ? starve + 1 : LIM;
                else if ((acc && !gp) || !rq[0]) starve = 0;
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
